imem_fetch: RTL and testbench

- Parametrised instruction memory with a registered fetch port and a program-load port.
- Sits between the core's fetch stage and the program store.
- Accepts fetch requests through a valid/ready handshake and returns words through a 2-entry response buffer, so back-pressure from a stalled core never drops a fetch.
- Flags misaligned and out-of-range fetches and substitutes a NOP word for them.

---
 rtl/imem_fetch.sv | 116 +++++++++++
 tb/tb_imem_fetch.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Instruction memory with a credit-checked fetch port, a one-cycle registered read,
// a 2-entry response buffer and a program-load port.
module imem_fetch #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] NOP_WORD  = 32'h00000013,
    parameter string       INIT_FILE = ""
) (
    input  logic                     clka,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [1:0]               rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data
);

    localparam int unsigned OFS    = $clog2(DATA_W / 8);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned WIDX_W = ADDR_W - OFS;
    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_WORD);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_pend;
    logic [DATA_W-1:0] r_rd_word;
    logic [1:0]        r_rd_err;

    logic [DATA_W-1:0] r_buf_data [2];
    logic [1:0]        r_buf_err  [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;

    logic [WIDX_W-1:0] w_widx;
    logic              w_mis;
    logic              w_oor;
    logic              w_pop;
    logic [2:0]        w_credit;
    logic              w_accept;
    logic [DATA_W-1:0] w_push_data;

    // Range check uses the full word index so high address bits never alias into the array.
    assign w_widx = req_addr[ADDR_W-1:OFS];
    assign w_mis  = |req_addr[OFS-1:0];
    assign w_oor  = (w_widx >= WIDX_W'(DEPTH));

    assign rsp_valid = (r_occ != 2'd0);
    assign rsp_data  = r_buf_data[r_rd_ptr];
    assign rsp_err   = r_buf_err[r_rd_ptr];

    assign w_pop    = rsp_valid && rsp_ready;
    assign w_credit = 3'(r_occ) + 3'(r_pend) - 3'(w_pop);
    assign req_ready = !rst && !ld_en && (w_credit < 3'd2);
    assign w_accept  = req_valid && req_ready;

    assign w_push_data = (r_rd_err != 2'b00) ? NOP : r_rd_word;

    // NOTE: the array has no reset; clearing it would turn the RAM into a register bank,
    // and reloading a program is the load port's job.
    always_ff @(posedge clka) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
        if (w_accept) begin
            r_rd_word <= r_mem[w_widx[IDX_W-1:0]];
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers update from the
    // same pre-edge values, regardless of statement order.
    always_ff @(posedge clka) begin
        if (rst) begin
            r_pend   <= 1'b0;
            r_rd_err <= 2'b00;
        end else begin
            r_pend <= w_accept;
            if (w_accept) begin
                r_rd_err <= {w_oor, w_mis};
            end
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_err[0]  <= 2'b00;
            r_buf_err[1]  <= 2'b00;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_occ         <= 2'd0;
        end else begin
            if (r_pend) begin
                r_buf_data[r_wr_ptr] <= w_push_data;
                r_buf_err[r_wr_ptr]  <= r_rd_err;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + 2'(r_pend) - 2'(w_pop);
        end
    end

    // The credit rule guarantees a pushed word always finds a free entry.
    a_no_overflow : assert property (@(posedge clka) disable iff (rst)
        !(r_pend && (r_occ == 2'd2) && !w_pop));

endmodule

// File: tb/tb_imem_fetch.sv
// Randomised and directed bench for imem_fetch with a queue-based reference model,
// plus a small directed check of a 16-bit, 128-word build.
module tb_imem_fetch;

    logic        clka = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        ld_en;
    logic [5:0]  ld_addr;
    logic [31:0] ld_data;

    logic        req16_valid;
    logic        req16_ready;
    logic [31:0] req16_addr;
    logic        rsp16_valid;
    logic        rsp16_ready;
    logic [15:0] rsp16_data;
    logic [1:0]  rsp16_err;
    logic        ld16_en;
    logic [6:0]  ld16_addr;
    logic [15:0] ld16_data;

    always #5 clka = ~clka;

    imem_fetch u_dut (
        .clka(clka), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_fetch #(.DATA_W(16), .DEPTH(128)) u_dut16 (
        .clka(clka), .rst(rst),
        .req_valid(req16_valid), .req_ready(req16_ready), .req_addr(req16_addr),
        .rsp_valid(rsp16_valid), .rsp_ready(rsp16_ready), .rsp_data(rsp16_data), .rsp_err(rsp16_err),
        .ld_en(ld16_en), .ld_addr(ld16_addr), .ld_data(ld16_data)
    );

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT at %0t", name, $time);
    endtask

    // Reference model: every accepted fetch is one entry, answered in order,
    // visible from the second edge after its accept edge.
    typedef struct {
        logic [31:0] data;
        logic [1:0]  err;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [64];
    logic [31:0] log_d[$];
    logic [1:0]  log_e[$];
    int          edge_no = 0;
    bit          chk_on = 1'b0;

    function automatic exp_t model_fetch(input logic [31:0] a, input int e);
        exp_t t;
        t.err[0] = (a % 4) != 0;
        t.err[1] = (a / 4) >= 64;
        t.data   = (t.err != 2'b00) ? 32'h0000_0013 : mem_m[a / 4];
        t.acc    = e;
        return t;
    endfunction

    always @(negedge clka) begin : model
        logic exp_valid;
        logic exp_ready;
        logic pop;
        int   outst;
        exp_valid = (q.size() > 0) && (q[0].acc + 2 <= edge_no);
        pop       = exp_valid && rsp_ready;
        outst     = q.size() - (pop ? 1 : 0);
        exp_ready = !rst && !ld_en && (outst < 2);
        if (chk_on) begin
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
                check("rsp_data", rsp_data, q[0].data);
                check("rsp_err", rsp_err, q[0].err);
            end
        end
        if (rst) begin
            q.delete();
        end else begin
            if (pop) begin
                log_d.push_back(q[0].data);
                log_e.push_back(q[0].err);
                void'(q.pop_front());
            end
            if (req_valid && exp_ready) begin
                q.push_back(model_fetch(req_addr, edge_no));
            end
        end
        if (ld_en) begin
            mem_m[ld_addr] = ld_data;
        end
        edge_no++;
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // Present a fetch and hold it until the accept edge; returns just after that edge.
    task automatic fetch(input logic [31:0] a, input string name);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clka);
        while (!req_ready && n < 50) begin
            @(negedge clka);
            n++;
        end
        if (n >= 50) timeout({name, "_accept"});
        stall_cnt += n;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_log(input int pos, input string name);
        int n;
        n = 0;
        while (log_d.size() <= pos && n < 50) begin
            @(negedge clka);
            n++;
        end
        if (log_d.size() <= pos) timeout({name, "_rsp"});
        step();
    endtask

    task automatic fetch_get(input logic [31:0] a, input string name,
                             output logic [31:0] d, output logic [1:0] e);
        int pos;
        pos = log_d.size() + q.size();
        fetch(a, name);
        wait_log(pos, name);
        d = (log_d.size() > pos) ? log_d[pos] : 32'hxxxx_xxxx;
        e = (log_e.size() > pos) ? log_e[pos] : 2'bxx;
    endtask

    task automatic fetch16(input logic [31:0] a, input logic [15:0] exp_d,
                           input logic [1:0] exp_e, input string name);
        int n;
        n = 0;
        req16_valid = 1'b1;
        req16_addr  = a;
        @(negedge clka);
        while (!req16_ready && n < 20) begin
            @(negedge clka);
            n++;
        end
        if (n >= 20) timeout({name, "_accept"});
        step();
        req16_valid = 1'b0;
        n = 0;
        @(negedge clka);
        while (!rsp16_valid && n < 20) begin
            @(negedge clka);
            n++;
        end
        if (!rsp16_valid) begin
            timeout({name, "_rsp"});
        end else begin
            check({name, "_data"}, rsp16_data, exp_d);
            check({name, "_err"}, rsp16_err, exp_e);
        end
        step();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : driver
        logic [31:0] d;
        logic [1:0]  e;
        int          base;
        int          r;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req16_valid = 1'b0; req16_addr = '0; rsp16_ready = 1'b1;
        ld16_en = 1'b0; ld16_addr = '0; ld16_data = '0;

        step();
        chk_on = 1'b1;
        step();
        @(negedge clka);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_rsp_err", rsp_err, 2'b00);
        check("reset_req_ready", req_ready, 1'b0);
        step();

        // Program load; the first words go in while reset is still held.
        for (int i = 0; i < 64; i++) begin
            ld_en   = 1'b1;
            ld_addr = 6'(i);
            ld_data = 32'h1000_0000 + 32'(i);
            if (i == 4) rst = 1'b0;
            step();
        end
        ld_en = 1'b0;

        // Sequential stream with a ready consumer.
        base = log_d.size();
        stall_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            fetch(32'(i) * 4, "stream");
        end
        check("stream_stalls", 64'(stall_cnt), 64'd0);
        wait_log(base + 63, "stream");
        check("stream_count", 64'(log_d.size() - base), 64'd64);
        check("stream_first", log_d[base], 32'h1000_0000);
        check("stream_last", log_d[base + 63], 32'h1000_003F);

        // Error fetches.
        fetch_get(32'h6, "misaligned", d, e);
        check("misaligned_err", e, 2'b01);
        check("misaligned_data", d, 32'h0000_0013);
        fetch_get(32'h100, "out_of_range", d, e);
        check("oor_err", e, 2'b10);
        check("oor_data", d, 32'h0000_0013);
        fetch_get(32'h1_0002, "both_err", d, e);
        check("both_err", e, 2'b11);
        fetch_get(32'hFFFF_FFFC, "no_alias", d, e);
        check("no_alias_err", e, 2'b10);
        fetch_get(32'hFC, "last_word", d, e);
        check("last_word_data", d, 32'h1000_003F);
        check("last_word_err", e, 2'b00);

        // Back-pressure: only two fetches may be outstanding, the head holds still.
        rsp_ready = 1'b0;
        base = log_d.size();
        fetch(32'h0, "bp0");
        fetch(32'h4, "bp4");
        req_valid = 1'b1;
        req_addr  = 32'h8;
        for (int k = 0; k < 4; k++) begin
            @(negedge clka);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_hold_data", rsp_data, 32'h1000_0000);
            step();
        end
        rsp_ready = 1'b1;
        fetch(32'h8, "bp8");
        wait_log(base + 2, "bp");
        repeat (3) step();
        check("bp_count", 64'(log_d.size() - base), 64'd3);
        check("bp_word0", log_d[base], 32'h1000_0000);
        check("bp_word1", log_d[base + 1], 32'h1000_0001);
        check("bp_word2", log_d[base + 2], 32'h1000_0002);

        // Load directly after a fetch of the same index, and fetches stalled by loads.
        base = log_d.size();
        fetch(32'd20, "pre_load");
        req_valid = 1'b1;
        req_addr  = 32'd24;
        for (int k = 0; k < 3; k++) begin
            ld_en   = 1'b1;
            ld_addr = (k == 0) ? 6'd5 : 6'(8 + k);
            ld_data = 32'hDEAD_0000 + 32'(ld_addr);
            @(negedge clka);
            check("ld_req_ready", req_ready, 1'b0);
            step();
        end
        ld_en = 1'b0;
        fetch(32'd24, "after_load");
        wait_log(base + 1, "load");
        check("ld_old_word", log_d[base], 32'h1000_0005);
        check("ld_next_word", log_d[base + 1], 32'h1000_0006);
        fetch_get(32'd20, "ld_new", d, e);
        check("ld_new_word", d, 32'hDEAD_0005);
        fetch_get(32'd36, "ld_new9", d, e);
        check("ld_new_word9", d, 32'hDEAD_0009);

        // Reset with two fetches outstanding: nothing stale may come out.
        rsp_ready = 1'b0;
        fetch(32'h0, "rst0");
        fetch(32'h4, "rst4");
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clka);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_data", rsp_data, 32'h0);
        step();
        rsp_ready = 1'b1;
        base = log_d.size();
        repeat (4) step();
        check("rst_no_stale", 64'(log_d.size() - base), 64'd0);
        fetch_get(32'd28, "rst_keep", d, e);
        check("rst_array_kept", d, 32'h1000_0007);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 7)       req_addr = 32'($urandom_range(0, 63)) * 4;
            else if (r == 7) req_addr = 32'($urandom_range(0, 255));
            else if (r == 8) req_addr = 32'h100 + 32'($urandom_range(0, 3)) * 4;
            else             req_addr = $urandom;
            rsp_ready = ($urandom_range(0, 9) < 7);
            ld_en     = ($urandom_range(0, 15) == 0);
            ld_addr   = 6'($urandom_range(0, 63));
            ld_data   = $urandom;
            rst       = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0; ld_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) step();

        // 16-bit, 128-word build.
        ld16_en = 1'b1; ld16_addr = 7'd1; ld16_data = 16'hBEEF;
        step();
        ld16_addr = 7'd127; ld16_data = 16'h1234;
        step();
        ld16_en = 1'b0;
        fetch16(32'h2, 16'hBEEF, 2'b00, "w16_word1");
        fetch16(32'h3, 16'h0013, 2'b01, "w16_misaligned");
        fetch16(32'h100, 16'h0013, 2'b10, "w16_oor");
        fetch16(32'hFE, 16'h1234, 2'b00, "w16_last");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
